mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit for the EX stage, sitting beside the ALU and fed by the ID/EX register.
//  Executes MULT/MULTU/DIV/DIVU with fixed latencies into HI/LO. Also executes MTHI/MTLO and supplies HI/LO for MFHI/MFLO.
//  Exports a busy indication to the hazard controller, which stalls any MD-class instruction in ID while an op is in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-high; clears all state
//  start     in   1   E-stage instruction is MULT/MULTU/DIV/DIVU (already qualified by valid)
//  op        in   3   MD operation code (see package constants)
//  wr_en     in   1   E-stage instruction is MTHI/MTLO
//  D1        in   32  rs operand (forwarded)
//  D2        in   32  rt operand (forwarded)
//  busy      out  1   registered; high while a mult/div is in progress
//  hi        out  32  architectural HI register
//  lo        out  32  architectural LO register
// BEHAVIOUR
//  Reset values: busy=0, hi=0, lo=0, internal counter=0, shadow result=0.
//  Idle (busy=0) + start=1 at edge:
//   - latch the full result into shadow hi/lo;
//   - load counter with MULT_CYCLES or DIV_CYCLES;
//   - busy=1 from the next cycle.
//  Busy:
//   - counter decrements each edge.
//   - On the edge where counter==1: commit shadow to hi/lo, busy->0, counter->0.
//   - Net: hi/lo update and busy falls exactly N edges after the start edge.
//  start while busy=1: ignored, no state change. The hazard controller guarantees this never happens.
//  wr_en while busy=1: ignored.
//  MTHI/MTLO (wr_en=1, busy=0): hi (or lo) <= D1 at the next edge. Single cycle; busy unaffected.
//  start and wr_en high together: protocol error. start wins.
//  hi/lo hold their old values throughout busy. MFHI/MFLO are stalled by hazard logic, never served stale.
//  Arithmetic:
//   - MULT: signed 32x32 -> 64, {hi,lo} = product.
//   - MULTU: unsigned 32x32 -> 64, {hi,lo} = product.
//   - DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//   - DIVU: unsigned. lo = quotient, hi = remainder.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   - Divide by zero (D2==0): operation still runs full DIV_CYCLES with busy; hi/lo are left unchanged at commit.
//  Reset asserted mid-operation: busy, counter and shadow clear immediately (async); hi/lo -> 0; the in-flight op is lost.
//  Hazard contract (implemented in the hazard controller, not here):
//   - stall the MD-class instruction in ID when (busy | start);
//   - the ID/EX bubble must force start=0 and wr_en=0.
// STRUCTURE
//  Shared constants in the global defines include:
//   - MD op codes: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MFHI=6, MDU_MFLO=7;
//   - default latencies.
//  Single module. The counter/busy FSM (IDLE, RUN) and the combinational result datapath stay inline.
//  Optional sub-module: mdu_signed_div, for the signed quotient/remainder fix-ups.
//  Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
// TESTING
//  1. MULT D1=0xFFFFFFFE, D2=0x00000003, start 1 cycle:
//     busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. MULTU with the same operands:
//     hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
//  3. DIV D1=0xFFFFFFF9 (-7), D2=2:
//     busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/2: lo=3, hi=1.
//  4. Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV by 0:
//     busy 10 cycles; hi=0x11, lo=0x22 unchanged.
//  5. During busy, pulse start (MULT 2*2) and wr_en (MTLO 0xAB):
//     both ignored; committed result is the original op's.
//  6. Assert reset at cycle 3 of a DIV:
//     busy=0, hi=lo=0 immediately, without waiting for a clock edge.
//     A new MULT 3*4 afterwards gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, default latencies and FSM state type for the EX-stage multiply/divide unit.
package mult_div_unit_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MFHI  = 3'd6;
    localparam logic [2:0] MDU_MFLO  = 3'd7;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_signed_div.sv
// Signed 32-bit divide: quotient truncated toward zero, remainder takes the dividend's sign.
module mult_div_unit_signed_div (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign neg_a = dividend[31];
    assign neg_b = divisor[31];
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign mag_a = neg_a ? (32'd0 - dividend) : dividend;
    assign mag_b = neg_b ? (32'd0 - divisor) : divisor;
    // A zero divisor's result is discarded upstream; avoid an X-producing divide.
    assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;

    assign q_mag = mag_a / mag_b_safe;
    assign r_mag = mag_a % mag_b_safe;

    assign quotient  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign remainder = neg_a ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit: result is computed at start, held in a shadow
// register, and committed to HI/LO when the busy counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        wr_en,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e         state;
    md_state_e         state_next;
    logic [CW-1:0]     cnt;
    logic [31:0]       sh_hi;
    logic [31:0]       sh_lo;
    logic              sh_wr;
    logic              accept;
    logic              commit;
    logic              mt_write;
    logic [63:0]       res;
    logic              res_wr;
    logic [CW-1:0]     load;
    logic signed [63:0] s_prod;
    logic [63:0]       u_prod;
    logic [31:0]       u_div_by;
    logic [31:0]       s_quo;
    logic [31:0]       s_rem;

    // Combinational result datapath, captured into the shadow on the start edge.
    assign s_prod   = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    assign u_prod   = {32'd0, D1} * {32'd0, D2};
    assign u_div_by = (D2 == 32'd0) ? 32'd1 : D2;

    mult_div_unit_signed_div u_sdiv (
        .dividend  (D1),
        .divisor   (D2),
        .quotient  (s_quo),
        .remainder (s_rem)
    );

    always_comb begin
        res    = 64'd0;
        res_wr = 1'b1;
        load   = CW'(MULT_CYCLES);
        case (op)
            MDU_MULT:  res = s_prod;
            MDU_MULTU: res = u_prod;
            MDU_DIV: begin
                res    = {s_rem, s_quo};
                res_wr = (D2 != 32'd0);
                load   = CW'(DIV_CYCLES);
            end
            MDU_DIVU: begin
                res    = {D1 % u_div_by, D1 / u_div_by};
                res_wr = (D2 != 32'd0);
                load   = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (accept) state_next = MD_RUN;
            MD_RUN:  if (commit) state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Output / control decode; start takes priority over wr_en.
    always_comb begin
        busy     = (state == MD_RUN);
        accept   = (state == MD_IDLE) && start && !op[2];
        commit   = (state == MD_RUN) && (cnt == CW'(1));
        mt_write = (state == MD_IDLE) && wr_en && !start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            sh_hi <= 32'd0;
            sh_lo <= 32'd0;
            sh_wr <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            if (accept) begin
                cnt   <= load;
                sh_hi <= res[63:32];
                sh_lo <= res[31:0];
                sh_wr <= res_wr;
            end else if (commit) begin
                cnt <= '0;
                if (sh_wr) begin
                    hi <= sh_hi;
                    lo <= sh_lo;
                end
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
            if (mt_write) begin
                if (op == MDU_MTHI)      hi <= D1;
                else if (op == MDU_MTLO) lo <= D1;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner-case sequences, and a randomized
// run scored against an arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        wr_en = 1'b0;
    logic [31:0] D1 = 32'd0;
    logic [31:0] D2 = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[9];

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .wr_en (wr_en),
        .D1    (D1),
        .D2    (D2),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: {hi,lo} after the op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        longint unsigned p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            MDU_MULT: begin
                q = sa * sb;
                return q;
            end
            MDU_MULTU: begin
                p = ua * ub;
                return p;
            end
            MDU_DIV: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {h, l};
                p = ua / ub;
                ua = ua % ub;
                return {ua[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Driver: launch one op and wait for busy to drop; optionally inject illegal pulses.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int cyc, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        held = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; D1 = a; D2 = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            if (inject) begin
                if (cyc == 2) begin
                    start = 1'b1; op = MDU_MULT; D1 = 32'd2; D2 = 32'd2;
                end else if (cyc == 3) begin
                    start = 1'b0; wr_en = 1'b1; op = MDU_MTLO; D1 = 32'hAB;
                end else begin
                    start = 1'b0; wr_en = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic mt_write(input logic [2:0] o, input logic [31:0] v, input string name);
        @(negedge clk);
        wr_en = 1'b1; op = o; D1 = v;
        @(negedge clk);
        wr_en = 1'b0;
        chk({name, " value"}, (o == MDU_MTHI) ? hi : lo, v);
        chk({name, " busy"}, busy, 1'b0);
    endtask

    initial begin
        int          cyc;
        bit          held;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;

        vecs[0] = '{"mult_neg",      MDU_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1] = '{"multu",         MDU_MULTU, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2] = '{"div_neg",       MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{"divu_7_2",      MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        DC};
        vecs[4] = '{"div_overflow",  MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DC};
        vecs[5] = '{"div_7_m2",      MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, DC};
        vecs[6] = '{"multu_max",     MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[7] = '{"mult_minmin",   MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        MC};
        vecs[8] = '{"divu_max_10",   MDU_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, DC};

        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc, held);
            chk({vecs[i].name, " cycles"}, cyc, vecs[i].cycles);
            chk({vecs[i].name, " held"}, held, 1'b1);
            chk({vecs[i].name, " hi"}, hi, vecs[i].hi);
            chk({vecs[i].name, " lo"}, lo, vecs[i].lo);
        end

        // Divide by zero leaves preloaded HI/LO intact
        mt_write(MDU_MTHI, 32'h11, "mthi");
        mt_write(MDU_MTLO, 32'h22, "mtlo");
        run_op(MDU_DIV, 32'd123, 32'd0, 1'b0, cyc, held);
        chk("div0 cycles", cyc, DC);
        chk("div0 hi", hi, 32'h11);
        chk("div0 lo", lo, 32'h22);
        run_op(MDU_DIVU, 32'd5, 32'd0, 1'b0, cyc, held);
        chk("divu0 cycles", cyc, DC);
        chk("divu0 hilo", {hi, lo}, {32'h11, 32'h22});

        // start and wr_en pulses during busy are ignored
        run_op(MDU_DIVU, 32'd100, 32'd7, 1'b1, cyc, held);
        chk("ignore cycles", cyc, DC);
        chk("ignore held", held, 1'b1);
        chk("ignore hi", hi, 32'd2);
        chk("ignore lo", lo, 32'd14);
        repeat (3) @(negedge clk);
        chk("ignore idle after", busy, 1'b0);
        chk("ignore hilo after", {hi, lo}, {32'd2, 32'd14});

        // start and wr_en together: start wins
        @(negedge clk);
        start = 1'b1; wr_en = 1'b1; op = MDU_MULTU; D1 = 32'd6; D2 = 32'd7;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        chk("collide busy", busy, 1'b1);
        repeat (MC) @(negedge clk);
        chk("collide done", busy, 1'b0);
        chk("collide hilo", {hi, lo}, {32'd0, 32'd42});

        // Asynchronous reset mid-divide
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; D1 = 32'd1000; D2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset busy before", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd42 - 32'd42);
        #1 reset = 1'b0;
        run_op(MDU_MULT, 32'd3, 32'd4, 1'b0, cyc, held);
        chk("post reset cycles", cyc, MC);
        chk("post reset hilo", {hi, lo}, {32'd0, 32'd12});

        // Randomized run scored against the reference model
        m_hi = 32'd0;
        m_lo = 32'd12;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom;
                o = ($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO;
                if (o == MDU_MTHI) m_hi = a; else m_lo = a;
                mt_write(o, a, "rand mt");
            end else begin
                o = 3'($urandom_range(0, 3));
                a = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1:       b = 32'($urandom_range(1, 9));
                    2:       b = 32'hFFFFFFFF;
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 3) == 0) a = 32'h80000000;
                exp_q.push_back(ref_model(o, a, b, m_hi, m_lo));
                {m_hi, m_lo} = exp_q[$];
                run_op(o, a, b, 1'b0, cyc, held);
                e = exp_q.pop_front();
                chk("rand cycles", cyc, o[1] ? DC : MC);
                chk("rand hi", hi, e[63:32]);
                chk("rand lo", lo, e[31:0]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
